// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic core.
// Holds operator codes, display glyph codes (the same codes are decoded by
// display_out), the core state encoding, default widths and a constant
// power-of-ten helper used for range limits.
package calc_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int BIN_W_DEF  = 14;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  localparam logic [3:0] BCD_MINUS = 4'hA;
  localparam logic [3:0] BCD_ERR   = 4'hE;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    OP_WAIT  = 3'd1,
    ENTER_B  = 3'd2,
    CALC     = 3'd3,
    CONV     = 3'd4,
    SHOW_RES = 3'd5,
    ERR      = 3'd6
  } state_e;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/calc_core_if.sv
// Key-event / display bundle between keyboard, calc_core and display_out.
//   num_val, op_val       : digit value / operator code, valid with their level
//   is_num, is_op, is_eq  : key levels from the keyboard
//   data_out_bcd          : BCD word to display_out, MS digit in top nibble
//   busy, err             : computing / error pattern shown
// master = key source and display sink, slave = calc_core.
interface calc_core_if #(
  parameter int DIGITS = calc_pkg::DIGITS_DEF
);
  logic [3:0]          num_val;
  logic [1:0]          op_val;
  logic                is_num;
  logic                is_op;
  logic                is_eq;
  logic [4*DIGITS-1:0] data_out_bcd;
  logic                busy;
  logic                err;

  modport master (
    output num_val, op_val, is_num, is_op, is_eq,
    input  data_out_bcd, busy, err
  );

  modport slave (
    input  num_val, op_val, is_num, is_op, is_eq,
    output data_out_bcd, busy, err
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
//   clk, rst : clock, asynchronous active-low reset
//   start    : load bin and begin; one bit is shifted per cycle for BIN_W cycles
//   bin      : binary input, sampled on start
//   done     : one-cycle pulse, bcd is valid from this cycle until the next start
//   bcd      : DIGITS packed BCD digits, MS digit in top nibble
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);
  localparam int OW  = 4*DIGITS;
  localparam int DCW = $clog2(BIN_W+1);

  logic [BIN_W-1:0] sh_q, sh_d;
  logic [OW-1:0]    acc_q, acc_d, adj;
  logic [DCW-1:0]   cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    sh_d   = sh_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    adj    = acc_q;
    // add-3 correction on every digit that would overflow past 9 when doubled
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    if (start) begin
      sh_d  = bin;
      acc_d = '0;
      cnt_d = DCW'(BIN_W);
    end else if (cnt_q != '0) begin
      acc_d  = {adj[OW-2:0], sh_q[BIN_W-1]};
      sh_d   = {sh_q[BIN_W-2:0], 1'b0};
      cnt_d  = cnt_q - DCW'(1);
      done_d = (cnt_q == DCW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = acc_q;
endmodule

// File: rtl/calc_core.sv
// Calculator arithmetic core: accumulates two decimal operands from key
// events, computes add/sub/mul/div on '=' and drives a BCD display word.
//   clk, rst : logic clock, asynchronous active-low reset
//   bus      : calc_core_if slave (key events in, data_out_bcd/busy/err out)
//
// state    | meaning
// ENTER_A  | shifting digits into operand A, display shows A
// OP_WAIT  | operator latched, display shows A, waiting for first B digit
// ENTER_B  | shifting digits into operand B, display shows B
// CALC     | add/sub/mul in one cycle, or restoring divide one bit per cycle
// CONV     | double-dabble of result magnitude running
// SHOW_RES | result displayed; digit restarts, operator chains
// ERR      | all-E displayed, err high; only a digit leaves
module calc_core
  import calc_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input logic        clk,
  input logic        rst,
  calc_core_if.slave bus
);
  localparam int OW  = 4*DIGITS;
  localparam int WW  = 2*BIN_W;
  localparam int CW  = $clog2(DIGITS+1);
  localparam int DCW = $clog2(BIN_W+1);
  localparam logic [WW-1:0] MAX_POS  = WW'(pow10(DIGITS) - 1);
  localparam logic [WW-1:0] MAX_NEG  = WW'(pow10(DIGITS-1) - 1);
  localparam logic [CW-1:0] DIG_C    = CW'(DIGITS);
  localparam logic [OW-1:0] ERR_WORD = {DIGITS{BCD_ERR}};

  state_e           state_q, state_d;
  logic [2:0]       key_q, key_prev_q;       // {eq, op, num}
  logic [3:0]       num_val_q;
  logic [1:0]       op_val_q;
  logic [BIN_W-1:0] a_q, a_d, b_q, b_d, res_bin_q, res_bin_d;
  op_e              op_q, op_d;
  logic [OW-1:0]    ent_bcd_q, ent_bcd_d, out_q, out_d;
  logic [CW-1:0]    ent_cnt_q, ent_cnt_d;
  logic             busy_q, busy_d, err_q, err_d, res_neg_q, res_neg_d;
  logic [BIN_W-1:0] div_rem_q, div_rem_d, div_quo_q, div_quo_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;

  logic [2:0]       rise;
  logic             eq_ev, op_ev, num_ev, digit_ok, room;
  logic [OW-1:0]    shift_bcd, first_bcd;
  logic [BIN_W-1:0] digit_bin;
  logic [WW-1:0]    a_w, b_w, mag;
  logic             neg, range_bad;
  logic [BIN_W:0]   div_sh;
  logic             div_ge;
  logic [BIN_W-1:0] div_rem_nx, div_quo_nx;
  logic             conv_start, conv_done;
  logic [BIN_W-1:0] conv_bin;
  logic [OW-1:0]    conv_bcd;

  // eq > op > num when edges coincide
  assign rise   = key_q & ~key_prev_q;
  assign eq_ev  = rise[2];
  assign op_ev  = rise[1] & ~rise[2];
  assign num_ev = rise[0] & ~rise[1] & ~rise[2];

  assign digit_ok  = (num_val_q <= 4'd9);
  assign room      = (ent_cnt_q < DIG_C);
  assign shift_bcd = {ent_bcd_q[OW-5:0], num_val_q};
  assign first_bcd = OW'(num_val_q);
  assign digit_bin = BIN_W'(num_val_q);

  assign a_w = WW'(a_q);
  assign b_w = WW'(b_q);

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (op_q)
      OP_ADD: mag = a_w + b_w;
      OP_SUB: begin
        if (a_q >= b_q) mag = a_w - b_w;
        else begin
          mag = b_w - a_w;
          neg = 1'b1;
        end
      end
      OP_MUL: mag = a_w * b_w;
      default: mag = '0;
    endcase
    // a negative result gives up the MS digit to the minus glyph
    range_bad = neg ? (mag > MAX_NEG) : (mag > MAX_POS);
  end

  // restoring division step; the remainder never exceeds the divisor
  assign div_sh     = {div_rem_q, div_quo_q[BIN_W-1]};
  assign div_ge     = (div_sh >= {1'b0, b_q});
  assign div_rem_nx = div_ge ? BIN_W'(div_sh - {1'b0, b_q}) : div_sh[BIN_W-1:0];
  assign div_quo_nx = {div_quo_q[BIN_W-2:0], div_ge};

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    ent_bcd_d  = ent_bcd_q;
    ent_cnt_d  = ent_cnt_q;
    out_d      = out_q;
    busy_d     = busy_q;
    err_d      = err_q;
    res_bin_d  = res_bin_q;
    res_neg_d  = res_neg_q;
    div_rem_d  = div_rem_q;
    div_quo_d  = div_quo_q;
    div_cnt_d  = div_cnt_q;
    conv_start = 1'b0;
    conv_bin   = '0;
    case (state_q)
      ENTER_A: begin
        if (op_ev) begin
          op_d    = op_e'(op_val_q);
          state_d = OP_WAIT;
        end else if (num_ev && digit_ok && room) begin
          a_d       = a_q * BIN_W'(10) + digit_bin;
          ent_bcd_d = shift_bcd;
          ent_cnt_d = ent_cnt_q + CW'(1);
          out_d     = shift_bcd;
        end
      end
      OP_WAIT: begin
        if (op_ev) begin
          op_d = op_e'(op_val_q);
        end else if (num_ev && digit_ok) begin
          b_d       = digit_bin;
          ent_bcd_d = first_bcd;
          ent_cnt_d = CW'(1);
          out_d     = first_bcd;
          state_d   = ENTER_B;
        end
      end
      ENTER_B: begin
        if (eq_ev) begin
          busy_d    = 1'b1;
          div_rem_d = '0;
          div_quo_d = a_q;
          div_cnt_d = DCW'(BIN_W);
          state_d   = CALC;
        end else if (num_ev && digit_ok && room) begin
          b_d       = b_q * BIN_W'(10) + digit_bin;
          ent_bcd_d = shift_bcd;
          ent_cnt_d = ent_cnt_q + CW'(1);
          out_d     = shift_bcd;
        end
      end
      CALC: begin
        if ((op_q == OP_DIV && b_q == '0) || (op_q != OP_DIV && range_bad)) begin
          busy_d  = 1'b0;
          err_d   = 1'b1;
          out_d   = ERR_WORD;
          state_d = ERR;
        end else if (op_q == OP_DIV) begin
          div_rem_d = div_rem_nx;
          div_quo_d = div_quo_nx;
          div_cnt_d = div_cnt_q - DCW'(1);
          // last quotient bit goes straight into the converter
          if (div_cnt_q == DCW'(1)) begin
            conv_start = 1'b1;
            conv_bin   = div_quo_nx;
            res_bin_d  = div_quo_nx;
            res_neg_d  = 1'b0;
            state_d    = CONV;
          end
        end else begin
          conv_start = 1'b1;
          conv_bin   = mag[BIN_W-1:0];
          res_bin_d  = mag[BIN_W-1:0];
          res_neg_d  = neg;
          state_d    = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
          out_d   = res_neg_q ? {BCD_MINUS, conv_bcd[OW-5:0]} : conv_bcd;
          busy_d  = 1'b0;
          state_d = SHOW_RES;
        end
      end
      SHOW_RES, ERR: begin
        if (op_ev) begin
          // chaining only from a non-negative result
          if (state_q == SHOW_RES && !res_neg_q) begin
            a_d     = res_bin_q;
            op_d    = op_e'(op_val_q);
            state_d = OP_WAIT;
          end
        end else if (num_ev && digit_ok) begin
          a_d       = digit_bin;
          b_d       = '0;
          ent_bcd_d = first_bcd;
          ent_cnt_d = CW'(1);
          out_d     = first_bcd;
          err_d     = 1'b0;
          res_neg_d = 1'b0;
          state_d   = ENTER_A;
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ENTER_A;
      key_q      <= '0;
      key_prev_q <= '0;
      num_val_q  <= '0;
      op_val_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      ent_bcd_q  <= '0;
      ent_cnt_q  <= '0;
      out_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      res_bin_q  <= '0;
      res_neg_q  <= 1'b0;
      div_rem_q  <= '0;
      div_quo_q  <= '0;
      div_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= {bus.is_eq, bus.is_op, bus.is_num};
      key_prev_q <= key_q;
      num_val_q  <= bus.num_val;
      op_val_q   <= bus.op_val;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      ent_bcd_q  <= ent_bcd_d;
      ent_cnt_q  <= ent_cnt_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      res_bin_q  <= res_bin_d;
      res_neg_q  <= res_neg_d;
      div_rem_q  <= div_rem_d;
      div_quo_q  <= div_quo_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

  bin2bcd_seq #(
    .DIGITS(DIGITS),
    .BIN_W (BIN_W)
  ) u_conv (
    .clk  (clk),
    .rst  (rst),
    .start(conv_start),
    .bin  (conv_bin),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  assign bus.data_out_bcd = out_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core: stimulus queues expected display words,
// a monitor pops and compares on every busy fall or explicit snapshot request.
module tb_calc_core;
  import calc_pkg::*;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic        err;
    int          len;   // >=0 busy cycles, -1 don't care, -2 idle snapshot
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic snap_req = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  calc_core_if #(.DIGITS(4)) bus ();

  calc_core #(.DIGITS(4), .BIN_W(14)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // monitor
  logic busy_prev = 1'b0;
  int   busy_len  = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (snap_req || (busy_prev && !bus.busy)) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected output: data %h with no expectation queued", bus.data_out_bcd);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, " data"}, 32'(bus.data_out_bcd), 32'(e.data));
        chk({e.name, " err"}, 32'(bus.err), 32'(e.err));
        if (e.len >= 0) chk({e.name, " busy cycles"}, 32'(busy_len), 32'(e.len));
        if (e.len == -2) chk({e.name, " busy"}, 32'(bus.busy), 32'd0);
      end
    end
    if (bus.busy) busy_len = busy_len + 1;
    else busy_len = 0;
    busy_prev = bus.busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_num(input logic [3:0] d);
    bus.num_val = d;
    bus.is_num  = 1'b1;
    tick(2);
    bus.is_num  = 1'b0;
    tick(2);
  endtask

  task automatic press_op(input op_e o);
    bus.op_val = o;
    bus.is_op  = 1'b1;
    tick(2);
    bus.is_op  = 1'b0;
    tick(2);
  endtask

  task automatic press_eq();
    bus.is_eq = 1'b1;
    tick(2);
    bus.is_eq = 1'b0;
    tick(2);
  endtask

  task automatic expect_out(input string name, input logic [15:0] d, input logic e, input int len);
    exp_t x;
    x.name = name;
    x.data = d;
    x.err  = e;
    x.len  = len;
    exp_q.push_back(x);
  endtask

  task automatic snap(input string name, input logic [15:0] d, input logic e);
    expect_out(name, d, e, -2);
    snap_req = 1'b1;
    @(negedge clk);
    #1 snap_req = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      tick(1);
      n++;
    end
    if (bus.busy) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: busy still high after %0d cycles", name, n);
    end
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus.num_val = 4'd0;
    bus.op_val  = 2'd0;
    bus.is_num  = 1'b0;
    bus.is_op   = 1'b0;
    bus.is_eq   = 1'b0;
    #2 rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    snap("reset", 16'h0000, 1'b0);

    // 12 + 34
    press_num(4'd1); press_num(4'd2);
    snap("entry_a", 16'h0012, 1'b0);
    press_op(OP_ADD); press_num(4'd3); press_num(4'd4);
    snap("entry_b", 16'h0034, 1'b0);
    expect_out("add", 16'h0046, 1'b0, 16);
    press_eq(); wait_idle("add");

    // 5 - 7, then op ignored on negative, digit starts fresh
    press_num(4'd5); press_op(OP_SUB); press_num(4'd7);
    expect_out("sub_neg", 16'hA002, 1'b0, 16);
    press_eq(); wait_idle("sub_neg");
    press_op(OP_ADD);
    snap("neg_op_ignored", 16'hA002, 1'b0);
    press_num(4'd3);
    snap("neg_fresh", 16'h0003, 1'b0);
    press_op(OP_ADD); press_num(4'd4);
    expect_out("after_neg", 16'h0007, 1'b0, 16);
    press_eq(); wait_idle("after_neg");

    // 1 - 2000 : magnitude too large for a minus display
    press_num(4'd1); press_op(OP_SUB);
    press_num(4'd2); press_num(4'd0); press_num(4'd0); press_num(4'd0);
    expect_out("sub_ovf", 16'hEEEE, 1'b1, -1);
    press_eq(); wait_idle("sub_ovf");

    // leaving ERR with a digit clears err; 99 * 999 overflows
    press_num(4'd9);
    snap("err_clear", 16'h0009, 1'b0);
    press_num(4'd9); press_op(OP_MUL);
    press_num(4'd9); press_num(4'd9); press_num(4'd9);
    expect_out("mul_ovf", 16'hEEEE, 1'b1, -1);
    press_eq(); wait_idle("mul_ovf");

    // 9 / 0
    press_num(4'd9); press_op(OP_DIV); press_num(4'd0);
    expect_out("div_zero", 16'hEEEE, 1'b1, -1);
    press_eq(); wait_idle("div_zero");

    // 100 / 7 = 14
    press_num(4'd1); press_num(4'd0); press_num(4'd0);
    press_op(OP_DIV); press_num(4'd7);
    expect_out("div", 16'h0014, 1'b0, 29);
    press_eq(); wait_idle("div");

    // digit limit and invalid digit
    press_num(4'd1); press_num(4'd2); press_num(4'd3); press_num(4'd4); press_num(4'd5);
    snap("five_digits", 16'h1234, 1'b0);
    press_num(4'hB);
    snap("bad_digit", 16'h1234, 1'b0);

    // held key gives one digit
    press_op(OP_ADD);
    bus.num_val = 4'd6;
    bus.is_num  = 1'b1;
    tick(50);
    bus.is_num  = 1'b0;
    tick(2);
    snap("held_key", 16'h0006, 1'b0);
    expect_out("add_1240", 16'h1240, 1'b0, 16);
    press_eq(); wait_idle("add_1240");

    // chaining, with a digit pressed while busy (must be dropped)
    press_num(4'd2); press_op(OP_ADD); press_num(4'd3);
    expect_out("chain1", 16'h0005, 1'b0, 16);
    press_eq(); wait_idle("chain1");
    press_op(OP_MUL); press_num(4'd4);
    expect_out("chain2", 16'h0020, 1'b0, 16);
    press_eq();
    press_num(4'd9);
    wait_idle("chain2");
    snap("busy_drop", 16'h0020, 1'b0);

    // reset in the middle of conversion
    press_num(4'd1); press_op(OP_ADD); press_num(4'd2);
    press_eq();
    tick(6);
    expect_out("reset_mid", 16'h0000, 1'b0, -1);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    press_num(4'd7);
    snap("after_reset", 16'h0007, 1'b0);

    tick(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      errors++;
      checks++;
      $display("FAIL %s: expectation never matched by an output", e.name);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
